// File: rtl/maxpool2x2_ctrl_if.sv
// Signal bundle between the 2x2 max-pool sequencer and its surroundings:
// layer handshake, input/output feature-map RAMs and the 4-input comparator.
interface maxpool2x2_ctrl_if #(
  parameter int in_length = 8,
  parameter int RD_AW     = 6,
  parameter int WR_AW     = 4
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 rd_en;
  logic [RD_AW-1:0]     rd_addr;
  logic [in_length-1:0] rd_data;
  logic [in_length-1:0] cmp_in1;
  logic [in_length-1:0] cmp_in2;
  logic [in_length-1:0] cmp_in3;
  logic [in_length-1:0] cmp_in4;
  logic                 cmp_start;
  logic [in_length-1:0] cmp_o;
  logic                 cmp_o_valid;
  logic                 wr_en;
  logic [WR_AW-1:0]     wr_addr;
  logic [in_length-1:0] wr_data;

  modport master (
    input  start, rd_data, cmp_o, cmp_o_valid,
    output busy, done, rd_en, rd_addr,
           cmp_in1, cmp_in2, cmp_in3, cmp_in4, cmp_start,
           wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data, cmp_o, cmp_o_valid,
    input  busy, done, rd_en, rd_addr,
           cmp_in1, cmp_in2, cmp_in3, cmp_in4, cmp_start,
           wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/maxpool2x2_ctrl.sv
// Sequencer for one 2x2 stride-2 max-pool pass: fetches each window's four
// pixels, runs the external comparator, and writes the result out.
module maxpool2x2_ctrl #(
  parameter int in_length = 8,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int RD_AW     = $clog2(IMG_W * IMG_H),
  parameter int WR_AW     = (((IMG_W / 2) * (IMG_H / 2)) > 1) ?
                            $clog2((IMG_W / 2) * (IMG_H / 2)) : 1
) (
  input logic             clk,
  input logic             reset,
  maxpool2x2_ctrl_if.master bus
);

  localparam int OW = IMG_W / 2;
  localparam int OH = IMG_H / 2;
  localparam int CW = (OW > 1) ? $clog2(OW) : 1;
  localparam int RW = (OH > 1) ? $clog2(OH) : 1;
  localparam logic [CW-1:0] WC_LAST = CW'(OW - 1);
  localparam logic [RW-1:0] WR_LAST = RW'(OH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_CMP1, S_CMP2, S_WAIT, S_WRITE, S_FIN
  } state_e;

  state_e                         state_q, state_d;
  logic [1:0]                     k_q, k_d;
  logic [CW-1:0]                  wc_q, wc_d;
  logic [RW-1:0]                  wr_q, wr_d;
  logic [3:0][in_length-1:0]      pix_q, pix_d;
  logic                           wr_en_q, wr_en_d;
  logic [WR_AW-1:0]               wr_addr_q, wr_addr_d;
  logic [in_length-1:0]           wr_data_q, wr_data_d;
  int                             rd_off;

  always_ff @(posedge clk) begin
    // NOTE: the pixel registers are cleared too, because they drive cmp_in1..4 directly.
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      wc_q      <= '0;
      wr_q      <= '0;
      pix_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of the others.
      state_q   <= state_d;
      k_q       <= k_d;
      wc_q      <= wc_d;
      wr_q      <= wr_d;
      pix_q     <= pix_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    // NOTE: every target gets a default first, so no path leaves it unassigned (no latch).
    state_d   = state_q;
    k_d       = k_q;
    wc_d      = wc_q;
    wr_d      = wr_q;
    pix_d     = pix_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          k_d     = 2'd0;
        end
      end
      S_FETCH: begin
        // Read data lags the strobe by one cycle, so slot k lands while fetching k+1.
        if (k_q != 2'd0) pix_d[k_q - 2'd1] = bus.rd_data;
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        pix_d[3] = bus.rd_data;
        state_d  = S_CMP1;
      end
      S_CMP1: state_d = S_CMP2;
      S_CMP2: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.cmp_o_valid) begin
          wr_data_d = bus.cmp_o;
          wr_addr_d = WR_AW'(int'(wr_q) * OW + int'(wc_q));
          wr_en_d   = 1'b1;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        k_d     = 2'd0;
        state_d = S_FETCH;
        if (wc_q == WC_LAST) begin
          wc_d = '0;
          if (wr_q == WR_LAST) begin
            wr_d    = '0;
            state_d = S_FIN;
          end else begin
            wr_d = wr_q + RW'(1);
          end
        end else begin
          wc_d = wc_q + CW'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_off = 0;
    case (k_q)
      2'd1:    rd_off = 1;
      2'd2:    rd_off = IMG_W;
      2'd3:    rd_off = IMG_W + 1;
      default: rd_off = 0;
    endcase
  end

  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_FIN);
  assign bus.done      = (state_q == S_FIN);
  assign bus.rd_en     = (state_q == S_FETCH);
  assign bus.rd_addr   = (state_q == S_FETCH) ?
                         RD_AW'(2 * IMG_W * int'(wr_q) + 2 * int'(wc_q) + rd_off) : '0;
  assign bus.cmp_start = (state_q == S_CMP1) || (state_q == S_CMP2);
  assign bus.cmp_in1   = pix_q[0];
  assign bus.cmp_in2   = pix_q[1];
  assign bus.cmp_in3   = pix_q[2];
  assign bus.cmp_in4   = pix_q[3];
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_maxpool2x2_ctrl.sv
// Self-checking bench for maxpool2x2_ctrl: a 4x4 and a 5x5 instance, each with
// a synchronous RAM model and a two-stage comparator model.
module tb_maxpool2x2_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  maxpool2x2_ctrl_if #(.in_length(8), .RD_AW(4), .WR_AW(2)) if4 ();
  maxpool2x2_ctrl_if #(.in_length(8), .RD_AW(5), .WR_AW(2)) if5 ();

  maxpool2x2_ctrl #(.in_length(8), .IMG_W(4), .IMG_H(4), .RD_AW(4), .WR_AW(2))
    u_dut4 (.clk(clk), .reset(reset), .bus(if4));
  maxpool2x2_ctrl #(.in_length(8), .IMG_W(5), .IMG_H(5), .RD_AW(5), .WR_AW(2))
    u_dut5 (.clk(clk), .reset(reset), .bus(if5));

  logic [7:0] mem4 [16];
  logic [7:0] mem5 [25];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (if4.rd_en) if4.rd_data <= mem4[if4.rd_addr];
    if (if5.rd_en) if5.rd_data <= mem5[if5.rd_addr];
  end

  function automatic logic [7:0] max4(input logic [7:0] a, b, c, d);
    logic [7:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Comparator models: result one cycle after the second enabled cycle,
  // optionally 3 cycles later for window delay_win of the 4x4 instance.
  logic       m4_stage, m4_valid, m5_stage, m5_valid, stray4;
  logic [7:0] m4_res, m5_res;
  int         m4_cd, m4_win;
  int         delay_win = -1;

  always @(posedge clk) begin
    if (reset) begin
      m4_stage <= 1'b0; m4_valid <= 1'b0; m4_cd <= 0; m4_win <= 0;
    end else begin
      m4_valid <= 1'b0;
      if (if4.start && !if4.busy) m4_win <= 0;
      if (if4.cmp_start) begin
        if (m4_stage) begin
          m4_stage <= 1'b0;
          m4_res   <= max4(if4.cmp_in1, if4.cmp_in2, if4.cmp_in3, if4.cmp_in4);
          m4_win   <= m4_win + 1;
          if (m4_win == delay_win) m4_cd <= 3;
          else m4_valid <= 1'b1;
        end else m4_stage <= 1'b1;
      end
      if (m4_cd > 0) begin
        m4_cd <= m4_cd - 1;
        if (m4_cd == 1) m4_valid <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      m5_stage <= 1'b0; m5_valid <= 1'b0;
    end else begin
      m5_valid <= 1'b0;
      if (if5.cmp_start) begin
        if (m5_stage) begin
          m5_stage <= 1'b0;
          m5_res   <= max4(if5.cmp_in1, if5.cmp_in2, if5.cmp_in3, if5.cmp_in4);
          m5_valid <= 1'b1;
        end else m5_stage <= 1'b1;
      end
    end
  end

  assign if4.cmp_o_valid = m4_valid | stray4;
  assign if4.cmp_o       = m4_valid ? m4_res : 8'hEE;
  assign if5.cmp_o_valid = m5_valid;
  assign if5.cmp_o       = m5_res;

  // Monitor: logs writes, reads, done pulses and comparator-operand stability.
  int  wa_q[$], wd_q[$], wt_q[$], ra_q[$];
  int  done_cnt = 0, unstable = 0;
  logic [31:0] snap;
  bit  in_wait;

  always @(negedge clk) begin
    if (if4.wr_en) begin wa_q.push_back(int'(if4.wr_addr)); wd_q.push_back(int'(if4.wr_data)); wt_q.push_back(cyc); end
    if (if5.wr_en) begin wa_q.push_back(int'(if5.wr_addr)); wd_q.push_back(int'(if5.wr_data)); wt_q.push_back(cyc); end
    if (if4.rd_en) ra_q.push_back(int'(if4.rd_addr));
    if (if5.rd_en) ra_q.push_back(int'(if5.rd_addr));
    if (if4.done || if5.done) done_cnt <= done_cnt + 1;
    if (reset) in_wait <= 1'b0;
    else begin
      if (in_wait && ({if4.cmp_in1, if4.cmp_in2, if4.cmp_in3, if4.cmp_in4} != snap))
        unstable <= unstable + 1;
      if (if4.cmp_start) begin
        snap    <= {if4.cmp_in1, if4.cmp_in2, if4.cmp_in3, if4.cmp_in4};
        in_wait <= 1'b1;
      end else if (if4.wr_en) in_wait <= 1'b0;
    end
  end

  int n_checks = 0, n_fail = 0;
  int start_cyc, b_w, b_r, b_d;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic fill(input int sel, input int mode);
    int n;
    n = (sel == 4) ? 16 : 25;
    for (int i = 0; i < n; i++) begin
      logic [7:0] v;
      case (mode)
        0:       v = 8'(i);
        1:       v = 8'(n - 1 - i);
        default: v = 8'((i * 37) & 255);
      endcase
      if (sel == 4) mem4[i] = v; else mem5[i] = v;
    end
  endtask

  task automatic snapshot();
    b_w = wa_q.size(); b_r = ra_q.size(); b_d = done_cnt;
  endtask

  task automatic pulse_start(input int sel);
    @(negedge clk);
    if (sel == 4) if4.start = 1'b1; else if5.start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    if4.start = 1'b0; if5.start = 1'b0;
  endtask

  task automatic wait_done(input int sel, output int lat);
    lat = -1;
    for (int i = 0; i < 2000; i++) begin
      if ((sel == 4) ? if4.done : if5.done) begin lat = cyc - start_cyc; break; end
      @(negedge clk);
    end
    if (lat < 0) check("done_timeout", lat, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_pass(input int sel, input int mode, output int lat);
    fill(sel, mode);
    snapshot();
    pulse_start(sel);
    wait_done(sel, lat);
  endtask

  task automatic check_writes(input string tag, input int d0, d1, d2, d3);
    int exp_d[4];
    int nw;
    exp_d = '{d0, d1, d2, d3};
    nw = wa_q.size() - b_w;
    check({tag, "_wr_count"}, nw, 4);
    for (int j = 0; j < 4; j++) begin
      if (j < nw) begin
        check($sformatf("%s_wr%0d_addr", tag, j), wa_q[b_w + j], j);
        check($sformatf("%s_wr%0d_data", tag, j), wd_q[b_w + j], exp_d[j]);
      end
    end
    check({tag, "_done_pulses"}, done_cnt - b_d, 1);
  endtask

  typedef struct {
    int sel; int mode; int d0; int d1; int d2; int d3; int lat;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int lat, nr, nw, cnt, found;
    logic [7:0] prev_wd;

    vecs[0] = '{4, 0,   5,   7,  13,  15, 37};
    vecs[1] = '{5, 1,  24,  22,  14,  12, 37};
    vecs[2] = '{4, 1,  15,  13,   7,   5, 37};
    vecs[3] = '{4, 2, 185, 222, 225, 151, 37};

    reset = 1'b1; if4.start = 1'b0; if5.start = 1'b0; stray4 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",      int'(if4.busy), 0);
    check("rst_done",      int'(if4.done), 0);
    check("rst_rd_en",     int'(if4.rd_en), 0);
    check("rst_cmp_start", int'(if4.cmp_start), 0);
    check("rst_wr_en",     int'(if4.wr_en), 0);
    check("rst_rd_addr",   int'(if4.rd_addr), 0);
    check("rst_wr_addr",   int'(if4.wr_addr), 0);
    check("rst_wr_data",   int'(if4.wr_data), 0);
    check("rst_cmp_in",    int'({if4.cmp_in1, if4.cmp_in2, if4.cmp_in3, if4.cmp_in4}), 0);
    check("rst_busy5",     int'(if5.busy), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      run_pass(vecs[v].sel, vecs[v].mode, lat);
      check_writes($sformatf("v%0d", v), vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].d3);
      check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      nw = wa_q.size() - b_w;
      if (nw >= 2) check($sformatf("v%0d_period", v), wt_q[b_w + 1] - wt_q[b_w], 9);
      nr = ra_q.size() - b_r;
      check($sformatf("v%0d_rd_count", v), nr, 16);
      if (nr >= 4) begin
        check($sformatf("v%0d_rd0", v), ra_q[b_r],     0);
        check($sformatf("v%0d_rd1", v), ra_q[b_r + 1], 1);
        check($sformatf("v%0d_rd2", v), ra_q[b_r + 2], vecs[v].sel);
        check($sformatf("v%0d_rd3", v), ra_q[b_r + 3], vecs[v].sel + 1);
      end
      if (vecs[v].sel == 5) begin
        cnt = 0;
        for (int i = b_r; i < ra_q.size(); i++)
          if (ra_q[i] == 4 || ra_q[i] == 9 || ra_q[i] == 14 || ra_q[i] >= 19) cnt++;
        check($sformatf("v%0d_unread_addrs", v), cnt, 0);
      end
    end

    // Comparator result late by 3 cycles on window 1.
    delay_win = 1;
    run_pass(4, 0, lat);
    delay_win = -1;
    check_writes("slow", 5, 7, 13, 15);
    check("slow_latency", lat, 40);
    nw = wa_q.size() - b_w;
    if (nw >= 3) begin
      check("slow_period_w1", wt_q[b_w + 1] - wt_q[b_w], 12);
      check("slow_period_w2", wt_q[b_w + 2] - wt_q[b_w + 1], 9);
    end
    check("cmp_in_stable", unstable, 0);

    // Second start pulse 10 cycles into a pass is ignored.
    fill(4, 2);
    snapshot();
    pulse_start(4);
    repeat (9) @(negedge clk);
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    wait_done(4, lat);
    check("restart_latency", lat, 37);
    check_writes("restart", 185, 222, 225, 151);
    repeat (60) @(negedge clk);
    check("restart_late_writes", wa_q.size() - b_w, 4);
    check("restart_late_done", done_cnt - b_d, 1);
    check("restart_idle_busy", int'(if4.busy), 0);

    // Reset during CMP2 of window 2 aborts the pass.
    fill(4, 0);
    snapshot();
    pulse_start(4);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wa_q.size() - b_w >= 2) begin found = 1; break; end
    end
    check("abort_two_writes", found, 1);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (if4.cmp_start) begin found = 1; break; end
    end
    check("abort_reach_cmp1", found, 1);
    @(negedge clk);
    check("abort_in_cmp2", int'(if4.cmp_start), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy",      int'(if4.busy), 0);
    check("abort_rd_en",     int'(if4.rd_en), 0);
    check("abort_cmp_start", int'(if4.cmp_start), 0);
    check("abort_wr_en",     int'(if4.wr_en), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_more_writes", wa_q.size() - b_w, 2);
    check("abort_no_done", done_cnt - b_d, 0);
    run_pass(4, 1, lat);
    check_writes("after_abort", 15, 13, 7, 5);
    check("after_abort_latency", lat, 37);

    // Stray comparator strobe while fetching is ignored.
    fill(4, 0);
    snapshot();
    pulse_start(4);
    prev_wd = if4.wr_data;
    stray4 = 1'b1;
    @(negedge clk);
    stray4 = 1'b0;
    check("stray_wr_en",   int'(if4.wr_en), 0);
    check("stray_wr_data", int'(if4.wr_data), int'(prev_wd));
    check("stray_rd_en",   int'(if4.rd_en), 1);
    @(negedge clk);
    check("stray_wr_en_next", int'(if4.wr_en), 0);
    wait_done(4, lat);
    check_writes("stray", 5, 7, 13, 15);
    check("stray_latency", lat, 37);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
